button_event_queue: RTL

BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

---
 rtl/button_event_queue.sv | 74 +++++++
 1 files changed

// File: rtl/button_event_queue.sv
// button_event_queue: edge-detects debounced button presses and queues their indices in a FIFO.
module button_event_queue #(
  parameter int NUM_BTN = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_BTN-1:0]       debounce,
  output logic [NUM_BTN-1:0]       acknowledge,
  output logic                     event_valid,
  output logic [1:0]               event_code,
  input  logic                     event_read,
  output logic [$clog2(DEPTH):0]   event_count,
  output logic                     overflow,
  input  logic                     clear_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH - NUM_BTN);
  logic [NUM_BTN-1:0] r_deb_q, r_pending, w_rise, w_mask, w_pend_n;
  logic               r_live;
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW:0]        r_count, w_count_n, w_pcnt;
  logic [1:0]         r_mem [DEPTH];
  logic [1:0]         w_sel;
  logic               w_hit, w_pop, w_enq, w_full, w_ovf_set;
  assign event_valid = r_count != '0;
  assign event_code  = r_mem[r_rptr];
  assign event_count = r_count;
  // r_live masks the first post-reset edge so a level held through reset is not seen as a press
  always_comb begin
    w_rise = debounce & ~r_deb_q & {NUM_BTN{r_live}};
    w_sel = '0;
    w_hit = 1'b0;
    for (int i = NUM_BTN-1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel = 2'(i);
        w_hit = 1'b1;
      end
    end
    w_full = r_count == (AW+1)'(DEPTH);
    w_pop = event_read && event_valid;
    w_enq = w_hit && (!w_full || w_pop);
    w_mask = w_enq ? NUM_BTN'(1) << w_sel : '0;
    w_pend_n = (r_pending & ~w_mask) | w_rise;
    w_ovf_set = |(w_rise & r_pending & ~w_mask);
    w_count_n = r_count + (AW+1)'(w_enq) - (AW+1)'(w_pop);
    w_pcnt = '0;
    for (int i = 0; i < NUM_BTN; i++) w_pcnt = w_pcnt + (AW+1)'(w_pend_n[i]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_deb_q     <= '0;
      r_live      <= 1'b0;
      r_pending   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      overflow    <= 1'b0;
      acknowledge <= '1;
    end else begin
      r_deb_q     <= debounce;
      r_live      <= 1'b1;
      r_pending   <= w_pend_n;
      r_count     <= w_count_n;
      if (w_enq) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      overflow    <= w_ovf_set | (overflow & ~clear_overflow);
      acknowledge <= {NUM_BTN{(w_count_n + w_pcnt) <= LIM}};
    end
  end
  always_ff @(posedge clock) begin
    if (w_enq) r_mem[r_wptr] <= w_sel;
  end
endmodule
